load_store_unit: RTL
====================

# load_store_unit

Memory-stage load/store unit placed directly upstream of the word-only `DataMemory`. It accepts one RV32I load or store per handshake and converts byte and halfword accesses into word-aligned memory cycles:
- loads: byte/halfword extraction plus sign or zero extension;
- sub-word stores: read-modify-write;
- misaligned accesses and illegal `funct3`: rejected with an error response.

## Interface
- `ADDR_WIDTH`, default 32: width of the request address and of `mem_access_addr`.
- `clk  in  1`: single clock; all state changes on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: unit idle; a request is accepted when `req_valid & req_ready` at a rising edge.
- `req_is_store  in  1`: 1 = store, 0 = load.
- `req_funct3  in  3`: RV32I width code.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `req_addr  in  ADDR_WIDTH`: byte address.
- `req_wdata  in  32`: store data; the value comes from rs2.
- `resp_valid  out  1`: one-cycle completion pulse.
- `resp_rdata  out  32`: extended load result; 0 for stores and errors.
- `resp_err  out  1`: access was misaligned or had an illegal `funct3`; valid with `resp_valid`.
- `mem_access_addr  out  ADDR_WIDTH`: word address, i.e. `{req_addr[ADDR_WIDTH-1:2], 2'b00}`.
- `mem_in  out  32`: write word.
- `mem_write_en  out  1`: memory write strobe; the memory commits on the rising edge.
- `mem_read_en  out  1`: memory read enable.
- `mem_out  in  32`: read data from memory; combinational, valid in the same cycle as `mem_read_en`.

## Operation
- **Request capture:** on acceptance, op, `funct3`, address, data and byte offset `off = req_addr[1:0]` are registered.
- **Lane layout:** little-endian; byte k occupies bits `[8k+7:8k]`. A halfword at offset 2 occupies bits `[31:16]`.
- **Error checks:**
  - Misaligned: halfword with `off[0] = 1`; word with `off != 0`.
  - Illegal: load `funct3` of 011, 110 or 111; store `funct3` with bit 2 set.
  - Erroneous requests perform no memory access.
- **FSM states:** IDLE, ACCESS, WRITE, RESP.
  - IDLE → RESP: accepted request that is erroneous; `resp_err = 1`.
  - IDLE → ACCESS: any other accepted request.
  - ACCESS, load: `mem_read_en = 1`. The extended result is registered into `resp_rdata`, then → RESP.
  - ACCESS, SW: `mem_write_en = 1` with `mem_in = wdata`, then → RESP.
  - ACCESS, SB/SH: `mem_read_en = 1`. The merged word (selected lane replaced by `wdata[7:0]` or `wdata[15:0]`) is registered, then → WRITE.
  - WRITE: `mem_write_en = 1`, `mem_in` = merged word, then → RESP.
  - RESP: `resp_valid = 1` for one cycle, then → IDLE.
- **Handshake and outputs:**
  - `req_ready = (state == IDLE)`; there is no request queuing.
  - `mem_read_en` and `mem_write_en` are decoded from the state register only.
  - `mem_access_addr` is held for the whole operation.
  - `mem_in` is 0 when no write is in progress.
- **Reset:**
  - Reset returns the FSM to IDLE and zeroes all registers.
  - Every output is 0 during and after reset, except `req_ready`, which is 1 after reset.
  - `mem_write_en` is gated by `~rst`, so no write commits in any cycle where `rst` is high. This applies even when reset occurs mid-WRITE.
  - An operation interrupted by reset produces no response.

## Timing
Cycle N is the accept edge.

| Operation | Memory activity | `resp_valid` cycle |
|---|---|---|
| Load | read in N+1 | N+2 |
| SW | write commits at end of N+1 | N+2 |
| SB / SH | read in N+1, write commits at end of N+2 | N+3 |
| Error | none | N+1 |

- `req_ready` drops the cycle after acceptance. It returns high in the cycle after RESP, so the next possible accept is at N+3, N+3, N+4 and N+2 respectively.
- `resp_rdata` and `resp_err` remain valid, held at their values, until the next acceptance.

## Structure
- **Package `lsu_pkg`:**
  - `funct3` localparams (LB/LH/LW/LBU/LHU, SB/SH/SW);
  - FSM state enum (`LSU_IDLE`, `LSU_ACCESS`, `LSU_WRITE`, `LSU_RESP`);
  - function `lsu_misaligned(funct3, off)`.
- **Sub-module `lsu_lane_mux`:** purely combinational; `load_extract(word, off, funct3) -> 32b` and `store_merge(word, wdata, off, funct3) -> 32b`.
- **Top level:** holds the FSM and registers only.

## Test plan
Preload word 0x0C = 0x8180_7F01 before each scenario.

- **Byte loads:**
  - LB 0x0D → `resp_rdata` 0x0000007F.
  - LB 0x0E → 0xFFFFFF80.
  - LBU 0x0E → 0x00000080.
  - All respond at N+2 with `resp_err = 0`.
- **Halfword and word loads:**
  - LH 0x0E → 0xFFFF8180.
  - LHU 0x0E → 0x00008180.
  - LW 0x0C → 0x81807F01.
- **Sub-word store:** SB 0x0D with `wdata` 0x123456AA.
  - Exactly one `mem_write_en` cycle, at N+2.
  - Word becomes 0x8180AA01.
  - Response at N+3.
- **Error cases:** SH 0x0F, LW 0x0E, and a load with `funct3` 011.
  - `resp_err = 1` at N+1.
  - `mem_read_en` and `mem_write_en` never assert.
  - Memory unchanged.
- **Reset during write:** SH 0x0C with `wdata` 0x00001234, with `rst` raised during the WRITE cycle.
  - No write commits; word stays 0x81807F01.
  - No `resp_valid`.
  - `req_ready = 1` in the cycle after reset.
- **Back-to-back requests:** `req_valid` held high with LW 0x0C followed by SW 0x0C (`wdata` 0xDEADBEEF).
  - Second request accepted at N+3.
  - Two single-cycle `resp_valid` pulses.
  - Word = 0xDEADBEEF.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_WRITE,
    LSU_RESP
  } lsu_state_e;

  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic lsu_illegal(input logic is_store, input logic [2:0] funct3);
    if (is_store) return funct3[2];
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the word-only memory port of the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_is_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] mem_access_addr;
  logic [31:0]           mem_in;
  logic                  mem_write_en;
  logic                  mem_read_en;
  logic [31:0]           mem_out;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_access_addr, mem_in, mem_write_en, mem_read_en
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_access_addr, mem_in, mem_write_en, mem_read_en
  );
endinterface

// File: rtl/load_store_unit_lane_mux.sv
// Combinational byte-lane logic: load extraction/extension and sub-word store merge.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] wdata_rep;
  logic [3:0]  lane_sel;

  assign byte_sh = word_i >> {off_i, 3'b000};
  assign half_sh = word_i >> {off_i[1], 4'b0000};

  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_LB:   load_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_LBU:  load_o = {24'h0, byte_sh[7:0]};
      F3_LH:   load_o = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_LHU:  load_o = {16'h0, half_sh[15:0]};
      F3_LW:   load_o = word_i;
      default: load_o = word_i;
    endcase
  end

  // Store data is replicated into every lane; lane_sel picks which lanes take it.
  always_comb begin
    lane_sel  = 4'b1111;
    wdata_rep = wdata_i;
    case (funct3_i[1:0])
      F3_SB[1:0]: begin
        lane_sel  = 4'b0001 << off_i;
        wdata_rep = {4{wdata_i[7:0]}};
      end
      F3_SH[1:0]: begin
        lane_sel  = 4'b0011 << {off_i[1], 1'b0};
        wdata_rep = {2{wdata_i[15:0]}};
      end
      default: begin
        lane_sel  = 4'b1111;
        wdata_rep = wdata_i;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_o[8*gi +: 8] = lane_sel[gi] ? wdata_rep[8*gi +: 8] : word_i[8*gi +: 8];
    end
  endgenerate
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit FSM: turns byte/halfword RV32I accesses into word-aligned
// memory cycles, with read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);
  lsu_state_e            state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           merged_q, merged_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0] load_data;
  logic [31:0] merged_data;
  logic        req_err;
  logic        is_sw;
  logic        write_phase;
  logic        run;

  lsu_lane_mux u_lane_mux (
    .word_i   (bus.mem_out),
    .wdata_i  (wdata_q),
    .off_i    (addr_q[1:0]),
    .funct3_i (funct3_q),
    .load_o   (load_data),
    .merged_o (merged_data)
  );

  assign req_err = lsu_illegal(bus.req_is_store, bus.req_funct3)
                 | lsu_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign is_sw   = is_store_q && (funct3_q == F3_SW);

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merged_d   = merged_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      LSU_IDLE: begin
        if (bus.req_valid) begin
          is_store_d = bus.req_is_store;
          funct3_d   = bus.req_funct3;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          merged_d   = '0;
          rdata_d    = '0;
          err_d      = req_err;
          state_d    = req_err ? LSU_RESP : LSU_ACCESS;
        end
      end
      LSU_ACCESS: begin
        if (!is_store_q) begin
          rdata_d = load_data;
          state_d = LSU_RESP;
        end else if (is_sw) begin
          state_d = LSU_RESP;
        end else begin
          merged_d = merged_data;
          state_d  = LSU_WRITE;
        end
      end
      LSU_WRITE: state_d = LSU_RESP;
      LSU_RESP:  state_d = LSU_IDLE;
      default:   state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LSU_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merged_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      merged_q   <= merged_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Every output is masked while rst is high, so an interrupted WRITE never commits.
  assign run         = ~rst;
  assign write_phase = ((state_q == LSU_ACCESS) && is_sw) || (state_q == LSU_WRITE);

  assign bus.req_ready       = run && (state_q == LSU_IDLE);
  assign bus.resp_valid      = run && (state_q == LSU_RESP);
  assign bus.resp_rdata      = run ? rdata_q : 32'h0;
  assign bus.resp_err        = run && err_q;
  assign bus.mem_access_addr = run ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_read_en     = run && (state_q == LSU_ACCESS) && !is_sw;
  assign bus.mem_write_en    = run && write_phase;
  assign bus.mem_in          = !(run && write_phase) ? 32'h0 :
                               (state_q == LSU_WRITE) ? merged_q : wdata_q;
endmodule
